rr_mux4_arbiter: RTL and testbench

RR_MUX4_ARBITER -- requirements
Module: rr_mux4_arbiter

---
 rtl/rr_mux4_arbiter_pkg.sv | 23 ++
 rtl/rr_mux4_arbiter_mux4.sv | 22 ++
 rtl/rr_mux4_arbiter.sv | 75 +++++++
 tb/tb_rr_mux4_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
package rr_mux4_arbiter_pkg;

   localparam int NUM_REQ = 4;

   typedef logic [1:0] req_idx_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      OWN  = 1'b1
   } state_t;

   // First set request bit searching upward from (p+1), wrapping, so p itself is checked last.
   function automatic req_idx_t rr_pick(input logic [NUM_REQ-1:0] r, input req_idx_t p);
      req_idx_t idx;
      rr_pick = p;
      for (int k = NUM_REQ; k >= 1; k--) begin
         idx = req_idx_t'(p + 2'(k));
         if (r[idx]) rr_pick = idx;
      end
   endfunction

endpackage

// File: rtl/rr_mux4_arbiter_mux4.sv
// Plain 4:1 data mux shared by the arbiter's data path.
module mux4 #(
   parameter int WIDTH = 8
) (
   input  logic [1:0]       sel,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      case (sel)
         2'd0:    y = d0;
         2'd1:    y = d1;
         2'd2:    y = d2;
         default: y = d3;
      endcase
   end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin 4-requester arbiter with burst ownership and a shared data mux.
module rr_mux4_arbiter
   import rr_mux4_arbiter_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MAX_BEATS = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ-1:0]   last,
   input  logic [WIDTH-1:0]     data0,
   input  logic [WIDTH-1:0]     data1,
   input  logic [WIDTH-1:0]     data2,
   input  logic [WIDTH-1:0]     data3,
   output logic [NUM_REQ-1:0]   grant,
   output logic [1:0]           sel,
   output logic                 valid,
   output logic [WIDTH-1:0]     dout,
   output logic                 busy
);

   localparam int CW = $clog2(MAX_BEATS + 1);
   localparam logic [CW-1:0] BEAT_LIM = CW'(MAX_BEATS - 1);

   state_t          state;
   req_idx_t        ptr;
   req_idx_t        win;
   logic [CW-1:0]   beats;
   logic            release_own;
   logic [WIDTH-1:0] mux_y;

   // ptr tracks sel while owning, so one pick covers both fresh and release arbitration.
   assign win = rr_pick(req, ptr);
   assign release_own = (state == OWN) &&
                        (!req[sel] || last[sel] || (beats == BEAT_LIM));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         grant <= '0;
         sel   <= '0;
         ptr   <= 2'd3;
         beats <= '0;
      end else if ((state == IDLE) || release_own) begin
         if (req != '0) begin
            state <= OWN;
            grant <= NUM_REQ'(1) << win;
            sel   <= win;
            ptr   <= win;
            beats <= '0;
         end else begin
            state <= IDLE;
            grant <= '0;
         end
      end else begin
         beats <= beats + 1'b1;
      end
   end

   assign busy  = (grant != '0);
   assign valid = busy && req[sel];

   mux4 #(.WIDTH(WIDTH)) u_mux (
      .sel (sel),
      .d0  (data0),
      .d1  (data1),
      .d2  (data2),
      .d3  (data3),
      .y   (mux_y)
   );

   assign dout = valid ? mux_y : '0;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Randomized self-checking bench for rr_mux4_arbiter against a behavioural owner/pointer model.
module tb_rr_mux4_arbiter;

   localparam int W  = 8;
   localparam int MB = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req, last;
   logic [W-1:0] data0, data1, data2, data3;
   logic [3:0]   grant;
   logic [1:0]   sel;
   logic         valid, busy;
   logic [W-1:0] dout;

   int n_cmp = 0;
   int n_bad = 0;

   // model: current owner (-1 = nobody), last winner, beats already transferred
   int m_own, m_ptr, m_sel, m_beats;

   always #5 clk = ~clk;

   rr_mux4_arbiter #(.WIDTH(W), .MAX_BEATS(MB)) dut (
      .clk(clk), .reset(reset), .req(req), .last(last),
      .data0(data0), .data1(data1), .data2(data2), .data3(data3),
      .grant(grant), .sel(sel), .valid(valid), .dout(dout), .busy(busy)
   );

   function automatic int pick(input logic [3:0] r, input int p);
      for (int k = 1; k <= 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   function automatic logic [3:0] exp_grant();
      return (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
   endfunction

   function automatic logic exp_valid();
      return (m_own >= 0) && req[m_own];
   endfunction

   function automatic logic [W-1:0] exp_dout();
      if (!exp_valid()) return '0;
      case (m_own)
         0: return data0;
         1: return data1;
         2: return data2;
         default: return data3;
      endcase
   endfunction

   task automatic grant_to(input int w);
      m_own = w; m_ptr = w; m_sel = w; m_beats = 0;
   endtask

   task automatic model_edge(input logic [3:0] r, input logic [3:0] l, input logic rs);
      if (!rs) begin
         m_own = -1; m_ptr = 3; m_sel = 0; m_beats = 0;
      end else if (m_own < 0) begin
         if (r != 0) grant_to(pick(r, m_ptr));
      end else if (!r[m_own] || l[m_own] || (m_beats + 1 == MB)) begin
         if (r != 0) grant_to(pick(r, m_own));
         else m_own = -1;
      end else begin
         m_beats++;
      end
   endtask

   task automatic set_in(input logic [3:0] r, input logic [3:0] l, input logic rs);
      req = r; last = l; reset = rs;
      data0 = W'($urandom); data1 = W'($urandom);
      data2 = W'($urandom); data3 = W'($urandom);
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge(req, last, reset);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 4; i++) begin
         set_in(4'($urandom), 4'($urandom), 1'b0);
         tick();
         set_in(4'b0000, 4'b0000, 1'b0);
         n_cmp++;
         if ({grant, sel, busy, valid, dout} !== {4'b0000, 2'd0, 1'b0, 1'b0, {W{1'b0}}}) begin
            n_bad++;
            $display("FAIL reset: grant=%b sel=%0d busy=%b valid=%b dout=%h, want all zero",
                     grant, sel, busy, valid, dout);
         end
      end
   endtask

   task automatic test_single_burst();
      int nv = 0;
      logic [3:0] lseq [6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
      logic [3:0] rseq [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
      set_in(4'b0000, 4'b0000, 1'b0); tick();
      for (int i = 0; i < 6; i++) begin
         set_in(rseq[i], lseq[i], 1'b1);
         if (i == 1) begin
            n_cmp++;
            if (grant !== 4'b0001) begin
               n_bad++; $display("FAIL burst_latency: grant=%b want 0001", grant);
            end
         end
         nv += int'(valid);
         n_cmp++;
         if (grant !== exp_grant() || valid !== exp_valid() || dout !== exp_dout()) begin
            n_bad++;
            $display("FAIL burst cyc%0d: grant=%b valid=%b dout=%h want %b %b %h",
                     i, grant, valid, dout, exp_grant(), exp_valid(), exp_dout());
         end
         tick();
      end
      n_cmp++;
      if (nv != 4 || grant !== 4'b0000) begin
         n_bad++; $display("FAIL burst_len: beats=%0d grant=%b want 4 beats then 0000", nv, grant);
      end
   endtask

   task automatic test_all_last();
      logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      set_in(4'b0000, 4'b0000, 1'b0); tick();
      set_in(4'b1111, 4'b1111, 1'b1); tick();
      for (int i = 0; i < 5; i++) begin
         set_in(4'b1111, 4'b1111, 1'b1);
         n_cmp++;
         if (grant !== seq[i] || grant !== exp_grant() || valid !== 1'b1 || dout !== exp_dout()) begin
            n_bad++;
            $display("FAIL rotate cyc%0d: grant=%b valid=%b dout=%h want %b 1 %h",
                     i, grant, valid, dout, seq[i], exp_dout());
         end
         tick();
      end
   endtask

   task automatic test_max_beats();
      set_in(4'b0000, 4'b0000, 1'b0); tick();
      set_in(4'b0110, 4'b0000, 1'b1); tick();
      for (int i = 0; i < 3 * MB + 1; i++) begin
         set_in(4'b0110, 4'b0000, 1'b1);
         n_cmp++;
         if (grant !== (((i / MB) % 2 == 0) ? 4'b0010 : 4'b0100) || grant !== exp_grant()
             || valid !== 1'b1 || dout !== exp_dout()) begin
            n_bad++;
            $display("FAIL max_beats cyc%0d: grant=%b valid=%b model=%b", i, grant, valid, exp_grant());
         end
         tick();
      end
   endtask

   task automatic test_solo_last();
      set_in(4'b1000, 4'b1000, 1'b1); tick();
      for (int i = 0; i < 4; i++) begin
         set_in(4'b1000, 4'b1000, 1'b1);
         n_cmp++;
         if (grant !== 4'b1000 || valid !== 1'b1 || dout !== data3 || sel !== 2'd3) begin
            n_bad++;
            $display("FAIL solo cyc%0d: grant=%b valid=%b sel=%0d want 1000 1 3", i, grant, valid, sel);
         end
         tick();
      end
   endtask

   task automatic test_reset_mid();
      set_in(4'b0000, 4'b0000, 1'b0); tick();
      set_in(4'b0100, 4'b0000, 1'b1); tick();
      set_in(4'b0100, 4'b0000, 1'b1); tick();
      set_in(4'b0100, 4'b0000, 1'b0); tick();
      set_in(4'b1111, 4'b0000, 1'b1);
      n_cmp++;
      if (grant !== 4'b0000 || valid !== 1'b0 || dout !== '0) begin
         n_bad++; $display("FAIL reset_mid: grant=%b valid=%b dout=%h want 0000 0 00", grant, valid, dout);
      end
      tick();
      set_in(4'b1111, 4'b0000, 1'b1);
      n_cmp++;
      if (grant !== 4'b0001 || grant !== exp_grant()) begin
         n_bad++; $display("FAIL reset_first: grant=%b want 0001", grant);
      end
   endtask

   task automatic test_drop();
      set_in(4'b0000, 4'b0000, 1'b0); tick();
      set_in(4'b0010, 4'b0000, 1'b1); tick();
      set_in(4'b0010, 4'b0000, 1'b1); tick();
      set_in(4'b1000, 4'b0000, 1'b1);
      n_cmp++;
      if (grant !== 4'b0010 || valid !== 1'b0 || dout !== '0) begin
         n_bad++; $display("FAIL drop_cycle: grant=%b valid=%b dout=%h want 0010 0 00", grant, valid, dout);
      end
      tick();
      set_in(4'b1000, 4'b0000, 1'b1);
      n_cmp++;
      if (grant !== 4'b1000 || grant !== exp_grant() || valid !== 1'b1) begin
         n_bad++; $display("FAIL drop_next: grant=%b valid=%b want 1000 1", grant, valid);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         set_in(4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                ($urandom_range(0, 60) != 0));
         n_cmp++;
         if (grant !== exp_grant() || valid !== exp_valid() || dout !== exp_dout()
             || busy !== (m_own >= 0) || (m_own >= 0 && sel !== 2'(m_sel))) begin
            n_bad++;
            $display("FAIL random cyc%0d: grant=%b sel=%0d valid=%b dout=%h busy=%b want %b %0d %b %h %b",
                     i, grant, sel, valid, dout, busy, exp_grant(), m_sel, exp_valid(), exp_dout(), m_own >= 0);
         end
         tick();
      end
   endtask

   initial begin
      m_own = -1; m_ptr = 3; m_sel = 0; m_beats = 0;
      req = '0; last = '0; reset = 1'b0;
      data0 = '0; data1 = '0; data2 = '0; data3 = '0;
      @(posedge clk); #1;
      test_reset();
      test_single_burst();
      test_all_last();
      test_max_beats();
      test_solo_last();
      test_reset_mid();
      test_drop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
